// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS definitions: opcode/funct enums, multi-cycle
//                controller state type, mux encodings and ALU control codes.
//                MIPS_MC_ILLEGAL_TRAP_EN adds the ILLEGAL controller state.
//  Revision    : 1.0 - multi-cycle controller support
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int MC_STATE_W = 5;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_SLLV = 6'h04,
        F_SRLV = 6'h06,
        F_SRAV = 6'h07,
        F_JR   = 6'h08,
        F_JALR = 6'h09,
        F_MFHI = 6'h10,
        F_MTHI = 6'h11,
        F_MFLO = 6'h12,
        F_MTLO = 6'h13,
        F_MULT = 6'h18,
        F_DIV  = 6'h1A,
        F_ADD  = 6'h20,
        F_SUB  = 6'h22,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A
    } funct_t;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADR   = 5'd2,
        S_MEMRD    = 5'd3,
        S_MEMWB    = 5'd4,
        S_MEMWR    = 5'd5,
        S_EXEC     = 5'd6,
        S_ALUWB    = 5'd7,
        S_HLWB     = 5'd8,
        S_MDU_WAIT = 5'd9,
        S_BRANCH   = 5'd10,
        S_ADDIEX   = 5'd11,
        S_ADDIWB   = 5'd12,
        S_JUMP     = 5'd13,
        S_JAL      = 5'd14
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        ,S_ILLEGAL = 5'd15
`endif
    } mc_state_t;

    localparam logic [1:0] c_srcb_rt      = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;
    localparam logic [1:0] c_pcsrc_rs     = 2'b11;

    localparam logic [2:0] c_wb_aluout = 3'b000;
    localparam logic [2:0] c_wb_mdr    = 3'b001;
    localparam logic [2:0] c_wb_hi     = 3'b010;
    localparam logic [2:0] c_wb_lo     = 3'b011;
    localparam logic [2:0] c_wb_pc     = 3'b100;

    localparam logic [1:0] c_regdst_rt = 2'b00;
    localparam logic [1:0] c_regdst_rd = 2'b01;
    localparam logic [1:0] c_regdst_ra = 2'b10;

    localparam logic [1:0] c_hilo_none = 2'b00;
    localparam logic [1:0] c_hilo_rs   = 2'b01;
    localparam logic [1:0] c_hilo_div  = 2'b10;
    localparam logic [1:0] c_hilo_mult = 2'b11;

    // Controller-to-decoder ALU request
    localparam logic [1:0] c_aluop_none  = 2'b00;
    localparam logic [1:0] c_aluop_add   = 2'b01;
    localparam logic [1:0] c_aluop_sub   = 2'b10;
    localparam logic [1:0] c_aluop_funct = 2'b11;

    localparam logic [3:0] c_alu_idle = 4'b0000;
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_xor  = 4'b0011;
    localparam logic [3:0] c_alu_nor  = 4'b0100;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_slt  = 4'b0111;
    localparam logic [3:0] c_alu_sll  = 4'b1000;
    localparam logic [3:0] c_alu_srl  = 4'b1001;
    localparam logic [3:0] c_alu_sra  = 4'b1010;
    localparam logic [3:0] c_alu_sllv = 4'b1011;
    localparam logic [3:0] c_alu_srlv = 4'b1100;
    localparam logic [3:0] c_alu_srav = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/mips_alu_decoder.sv
// ============================================================================
//  Module      : mips_alu_decoder
//  Description : Combinational ALU control decode from controller request
//                and R-type funct field.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_decoder
    import mips_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic [1:0]                aluop,
    input  logic [5:0]                funct,
    output logic [ALU_CTRL_WIDTH-1:0] alucontrl
);

    logic [3:0] w_code;

    always_comb begin
        w_code = c_alu_add;
        case (aluop)
            c_aluop_none: w_code = c_alu_idle;
            c_aluop_add:  w_code = c_alu_add;
            c_aluop_sub:  w_code = c_alu_sub;
            default: begin
                case (funct)
                    F_AND:   w_code = c_alu_and;
                    F_OR:    w_code = c_alu_or;
                    F_ADD:   w_code = c_alu_add;
                    F_XOR:   w_code = c_alu_xor;
                    F_NOR:   w_code = c_alu_nor;
                    F_SUB:   w_code = c_alu_sub;
                    F_SLT:   w_code = c_alu_slt;
                    F_SLL:   w_code = c_alu_sll;
                    F_SRL:   w_code = c_alu_srl;
                    F_SRA:   w_code = c_alu_sra;
                    F_SLLV:  w_code = c_alu_sllv;
                    F_SRLV:  w_code = c_alu_srlv;
                    F_SRAV:  w_code = c_alu_srav;
                    default: w_code = c_alu_add;
                endcase
            end
        endcase
    end

    assign alucontrl = ALU_CTRL_WIDTH'(w_code);

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// ============================================================================
//  Module      : mips_mc_controller
//  Description : Multi-cycle MIPS control FSM with MDU start/done handshake.
//                MIPS_MC_ILLEGAL_TRAP_EN adds a sticky illegal-opcode trap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int STATE_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic                      zero,
    input  logic                      mdu_done,
    output logic                      pc_write,
    output logic                      iord,
    output logic                      mem_write,
    output logic                      ir_write,
    output logic                      reg_write,
    output logic [1:0]                regdst,
    output logic [2:0]                write_back_sel,
    output logic                      alusrca,
    output logic [1:0]                alusrcb,
    output logic [1:0]                pcsrc,
    output logic [ALU_CTRL_WIDTH-1:0] alucontrl,
    output logic                      hi_write,
    output logic                      lo_write,
    output logic [1:0]                hi_select,
    output logic [1:0]                lo_select,
    output logic                      mdu_start,
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    output logic                      illegal_instr,
`endif
    output logic [STATE_WIDTH-1:0]    state
);

    mc_state_t  r_state;
    mc_state_t  w_next;
    logic [1:0] w_aluop;
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_opcode = instr[INSTR_WIDTH-1 -: 6];
    assign w_funct  = instr[5:0];
    assign w_unused = ^instr[INSTR_WIDTH-7:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = S_FETCH;
        pc_write       = 1'b0;
        iord           = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        regdst         = c_regdst_rt;
        write_back_sel = c_wb_aluout;
        alusrca        = 1'b0;
        alusrcb        = c_srcb_rt;
        pcsrc          = c_pcsrc_alu;
        w_aluop        = c_aluop_none;
        hi_write       = 1'b0;
        lo_write       = 1'b0;
        hi_select      = c_hilo_none;
        lo_select      = c_hilo_none;
        mdu_start      = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                alusrcb  = c_srcb_four;
                w_aluop  = c_aluop_add;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = c_srcb_imm_sl2;
                w_aluop = c_aluop_add;
                case (w_opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    OP_JAL:       w_next = S_JAL;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    default:      w_next = S_ILLEGAL;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = c_srcb_imm;
                w_aluop = c_aluop_add;
                w_next  = (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write      = 1'b1;
                regdst         = c_regdst_rt;
                write_back_sel = c_wb_mdr;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                alusrcb = c_srcb_rt;
                w_aluop = c_aluop_funct;
                case (w_funct)
                    F_MULT, F_DIV: begin
                        mdu_start = 1'b1;
                        w_next    = S_MDU_WAIT;
                    end
                    F_MFHI, F_MFLO: w_next = S_HLWB;
                    F_MTHI: begin
                        hi_write  = 1'b1;
                        hi_select = c_hilo_rs;
                    end
                    F_MTLO: begin
                        lo_write  = 1'b1;
                        lo_select = c_hilo_rs;
                    end
                    F_JR: begin
                        pcsrc    = c_pcsrc_rs;
                        pc_write = 1'b1;
                    end
                    F_JALR: begin
                        pcsrc          = c_pcsrc_rs;
                        pc_write       = 1'b1;
                        reg_write      = 1'b1;
                        regdst         = c_regdst_ra;
                        write_back_sel = c_wb_pc;
                    end
                    default: w_next = S_ALUWB;
                endcase
            end
            S_ALUWB: begin
                reg_write      = 1'b1;
                regdst         = c_regdst_rd;
                write_back_sel = c_wb_aluout;
            end
            S_HLWB: begin
                reg_write      = 1'b1;
                regdst         = c_regdst_rd;
                write_back_sel = (w_funct == F_MFLO) ? c_wb_lo : c_wb_hi;
            end
            // A done pulse coinciding with mdu_start is never seen here, since
            // that cycle is spent in EXEC.
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    hi_write  = 1'b1;
                    lo_write  = 1'b1;
                    hi_select = (w_funct == F_MULT) ? c_hilo_mult : c_hilo_div;
                    lo_select = (w_funct == F_MULT) ? c_hilo_mult : c_hilo_div;
                end else begin
                    w_next = S_MDU_WAIT;
                end
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = c_aluop_sub;
                pcsrc    = c_pcsrc_aluout;
                pc_write = zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = c_srcb_imm;
                w_aluop = c_aluop_add;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write      = 1'b1;
                regdst         = c_regdst_rt;
                write_back_sel = c_wb_aluout;
            end
            S_JUMP: begin
                pcsrc    = c_pcsrc_jump;
                pc_write = 1'b1;
            end
            S_JAL: begin
                pcsrc          = c_pcsrc_jump;
                pc_write       = 1'b1;
                reg_write      = 1'b1;
                regdst         = c_regdst_ra;
                write_back_sel = c_wb_pc;
            end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_ILLEGAL: w_next = S_ILLEGAL;
`endif
            default: w_next = S_FETCH;
        endcase

        // Held reset silences every control output, including FETCH's.
        if (!rst_n) begin
            pc_write       = 1'b0;
            iord           = 1'b0;
            mem_write      = 1'b0;
            ir_write       = 1'b0;
            reg_write      = 1'b0;
            regdst         = c_regdst_rt;
            write_back_sel = c_wb_aluout;
            alusrca        = 1'b0;
            alusrcb        = c_srcb_rt;
            pcsrc          = c_pcsrc_alu;
            w_aluop        = c_aluop_none;
            hi_write       = 1'b0;
            lo_write       = 1'b0;
            hi_select      = c_hilo_none;
            lo_select      = c_hilo_none;
            mdu_start      = 1'b0;
        end
    end

    mips_alu_decoder #(
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_alu_decoder (
        .aluop     (w_aluop),
        .funct     (w_funct),
        .alucontrl (alucontrl)
    );

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    assign illegal_instr = rst_n && (r_state == S_ILLEGAL);
`endif

    assign state = STATE_WIDTH'(r_state);

endmodule

`default_nettype wire
